risc8_com_responder: RTL and testbench
======================================

Name: risc8_com_responder

Overview:
- Co-processor-side responder for the risc8 COM instruction; the CPU issues COM as initiator, and this block is the target that answers.
- Implements co-processor slot 0x03 (GPIO): an output port, a synchronised input port, and a byte mailbox.
- The mailbox has an RX FIFO, filled from an external byte stream and popped by CPU reads.
- It also has a TX FIFO, pushed by CPU writes and drained to an external byte stream.
- Sits on the COM bus next to the datapath's SO_COM/SR_COM paths.

Parameters:
- BASE_ADDR, 8'h0C: register block base; low 2 bits must be 0; hit when com_addr[7:2]==BASE_ADDR[7:2].
- FIFO_DEPTH, 4: entries per FIFO; power of 2, at least 2.
- GPIO_W, 8: width of gpio_out/gpio_in; at most 8.

Ports:
- clk, input, 1: clock, all logic on rising edge.
- rst, input, 1: synchronous reset, active-high.
- com_req, input, 1: one-cycle request strobe from CPU.
- com_wr, input, 1: 1 = write, 0 = read; valid with com_req.
- com_addr, input, 8: register address; valid with com_req.
- com_wdata, input, 8: write data; valid with com_req.
- com_ack, output, 1: one-cycle acknowledge.
- com_rdata, output, 8: read data; valid while com_ack=1, else 0.
- gpio_out, output, GPIO_W: output port register.
- gpio_in, input, GPIO_W: asynchronous input pins.
- in_valid, input, 1: RX stream byte valid.
- in_data, input, 8: RX stream byte.
- in_ready, output, 1: RX FIFO can accept.
- out_valid, output, 1: TX FIFO non-empty.
- out_data, output, 8: TX head byte.
- out_ready, input, 1: downstream accepts.
- irq, output, 1: level interrupt, = rx_nonempty & ie_rx | tx_empty & ie_tx.

Behaviour:
Reset (rst=1 at an edge):
- com_ack=0, com_rdata=0, gpio_out=0.
- Both FIFOs empty, so in_ready=1, out_valid=0, out_data=0.
- Sticky flags and ie bits cleared; sync flops cleared.
- A request in flight is discarded: no ack. Reset overrides all same-cycle events.

Register map, offset = com_addr[1:0]:
- 0 GPIO_OUT: RW.
- 1 GPIO_IN: RO, returns the 2-flop-synchronised gpio_in zero-extended; writes ignored.
- 2 DATA: a read pops RX and returns its head; a write pushes com_wdata into TX.
- 3 STATUS: [0] rx_empty, [1] rx_full, [2] tx_empty, [3] tx_full, [4] rx_underflow (sticky), [5] tx_overflow (sticky), [6] ie_rx, [7] ie_tx.
- STATUS write: bits 4-5 are write-1-to-clear; bits 6-7 load directly; bits 0-3 ignored.

Handshake / FSM:
- States IDLE and ACK.
- IDLE, com_req=1 with address hit: perform the access at that edge, go to ACK. com_ack=1 and com_rdata are registered during ACK, i.e. exactly 1 cycle of latency.
- ACK: return to IDLE next edge unconditionally. A com_req seen in ACK is ignored; the CPU must not issue back-to-back requests.
- com_req with address miss: no state change, no ack; another responder answers.

FIFOs:
- Circular buffers with pointer width log2(FIFO_DEPTH)+1; wrap-around via the MSB.
- full = pointers equal except the MSB; empty = pointers fully equal.
- in_ready = !rx_full, from the registered state. A push occurs when in_valid & in_ready.
- RX: a CPU pop and a stream push in the same cycle are both performed. When RX is empty, the pop sees empty: returns 8'h00 and sets rx_underflow, while the push still lands.
- TX: out_data = head entry, or 0 when empty. A pop occurs when out_valid & out_ready.
- TX: a CPU push and a stream pop in the same cycle are both performed. When TX is full, the CPU push is dropped and tx_overflow is set, even if a pop occurs that cycle.
- Status bits reflect the state before the current access.

Sticky flags:
- A set and a W1C clear in the same cycle: set wins.

Test Plan:
- Reset, then read STATUS (com_addr=0x0F) -> ack 1 cycle later, rdata=8'h05; gpio_out=0; in_ready=1; out_valid=0.
- Write 0xA5 to 0x0C, then read 0x0C -> gpio_out=0xA5 the cycle after the req edge; read returns 0xA5. Drive gpio_in=0x3C, wait 2 cycles, read 0x0D -> 0x3C.
- Stream in 0x11,0x22,0x33,0x44 -> in_ready falls after the 4th; STATUS=0x06; four reads of 0x0E -> 0x11,0x22,0x33,0x44; 5th read -> 0x00 and STATUS bit4=1; write 0x10 to 0x0F -> bit4 clears.
- Hold out_ready=0; write 0x01..0x05 to 0x0E -> 5th dropped, tx_overflow=1. Raise out_ready -> out_data sequence 0x01..0x04, then out_valid=0.
- Write com_addr=0x20 -> no com_ack, no state change. Issue com_req on two consecutive cycles -> only the first is acked.
- Write STATUS 0x40 with RX empty -> irq=0. Push one byte -> irq=1 the next cycle. Assert rst mid-ACK -> com_ack=0, FIFOs empty, irq=0.

Source files
------------

// File: rtl/risc8_com_responder_if.sv
// rtl/risc8_com_responder_if.sv - COM bus between the risc8 initiator and a co-processor responder
interface risc8_com_responder_if;
   logic       com_req;
   logic       com_wr;
   logic [7:0] com_addr;
   logic [7:0] com_wdata;
   logic       com_ack;
   logic [7:0] com_rdata;

   modport master (
      output com_req, com_wr, com_addr, com_wdata,
      input  com_ack, com_rdata
   );

   modport slave (
      input  com_req, com_wr, com_addr, com_wdata,
      output com_ack, com_rdata
   );
endinterface

// File: rtl/risc8_com_responder.sv
// rtl/risc8_com_responder.sv - COM slot 0x03 GPIO responder: output port, synced input port, RX/TX byte mailbox
module risc8_com_responder #(
   parameter logic [7:0]  BASE_ADDR  = 8'h0C,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned GPIO_W     = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   risc8_com_responder_if.slave  com,
   output logic [GPIO_W-1:0]     gpio_out,
   input  logic [GPIO_W-1:0]     gpio_in,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   output logic                  out_valid,
   output logic [7:0]            out_data,
   input  logic                  out_ready,
   output logic                  irq
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned PW = AW + 1;

   typedef enum logic {ST_IDLE, ST_ACK} state_e;

   state_e            state_q;
   logic              ack_q;
   logic [7:0]        rdata_q, rdata_d;
   logic [GPIO_W-1:0] gpio_out_q, sync1_q, sync2_q;
   logic [7:0]        rx_mem [FIFO_DEPTH];
   logic [7:0]        tx_mem [FIFO_DEPTH];
   logic [PW-1:0]     rx_wp_q, rx_rp_q, tx_wp_q, tx_rp_q;
   logic              rx_uf_q, rx_uf_d, tx_of_q, tx_of_d;
   logic              ie_rx_q, ie_tx_q;

   logic       rx_empty, rx_full, tx_empty, tx_full;
   logic       access, stat_wr;
   logic [1:0] off;
   logic       rx_push, rx_pop_req, rx_pop, tx_push_req, tx_push, tx_pop;
   logic [7:0] status, gpio_out_ext, gpio_in_ext, rx_head, tx_head;

   // Wrap bit distinguishes full from empty when the index bits match.
   assign rx_empty = (rx_wp_q == rx_rp_q);
   assign rx_full  = (rx_wp_q[AW] != rx_rp_q[AW]) && (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]);
   assign tx_empty = (tx_wp_q == tx_rp_q);
   assign tx_full  = (tx_wp_q[AW] != tx_rp_q[AW]) && (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]);

   assign off         = com.com_addr[1:0];
   assign access      = (state_q == ST_IDLE) && com.com_req && (com.com_addr[7:2] == BASE_ADDR[7:2]);
   assign stat_wr     = access && com.com_wr && (off == 2'd3);
   assign rx_push     = in_valid && !rx_full;
   assign rx_pop_req  = access && !com.com_wr && (off == 2'd2);
   assign rx_pop      = rx_pop_req && !rx_empty;
   assign tx_push_req = access && com.com_wr && (off == 2'd2);
   assign tx_push     = tx_push_req && !tx_full;
   assign tx_pop      = !tx_empty && out_ready;

   assign rx_head = rx_mem[rx_rp_q[AW-1:0]];
   assign tx_head = tx_mem[tx_rp_q[AW-1:0]];
   assign status  = {ie_tx_q, ie_rx_q, tx_of_q, rx_uf_q, tx_full, tx_empty, rx_full, rx_empty};

   always_comb begin
      gpio_out_ext = '0;
      gpio_in_ext  = '0;
      gpio_out_ext[GPIO_W-1:0] = gpio_out_q;
      gpio_in_ext[GPIO_W-1:0]  = sync2_q;
   end

   always_comb begin
      rdata_d = 8'h00;
      if (!com.com_wr) begin
         case (off)
            2'd0: rdata_d = gpio_out_ext;
            2'd1: rdata_d = gpio_in_ext;
            2'd2: rdata_d = rx_empty ? 8'h00 : rx_head;
            2'd3: rdata_d = status;
         endcase
      end
   end

   // A same-cycle set beats a write-1-to-clear.
   always_comb begin
      rx_uf_d = rx_uf_q;
      tx_of_d = tx_of_q;
      if (stat_wr && com.com_wdata[4]) rx_uf_d = 1'b0;
      if (stat_wr && com.com_wdata[5]) tx_of_d = 1'b0;
      if (rx_pop_req && rx_empty)      rx_uf_d = 1'b1;
      if (tx_push_req && tx_full)      tx_of_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wp_q[AW-1:0]] <= in_data;
      if (tx_push) tx_mem[tx_wp_q[AW-1:0]] <= com.com_wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         ack_q      <= 1'b0;
         rdata_q    <= 8'h00;
         gpio_out_q <= '0;
         sync1_q    <= '0;
         sync2_q    <= '0;
         rx_wp_q    <= '0;
         rx_rp_q    <= '0;
         tx_wp_q    <= '0;
         tx_rp_q    <= '0;
         rx_uf_q    <= 1'b0;
         tx_of_q    <= 1'b0;
         ie_rx_q    <= 1'b0;
         ie_tx_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (access) begin
                  state_q <= ST_ACK;
                  ack_q   <= 1'b1;
                  rdata_q <= rdata_d;
               end
            end
            ST_ACK: begin
               state_q <= ST_IDLE;
               ack_q   <= 1'b0;
               rdata_q <= 8'h00;
            end
            default: begin
               state_q <= ST_IDLE;
               ack_q   <= 1'b0;
               rdata_q <= 8'h00;
            end
         endcase
         if (access && com.com_wr && (off == 2'd0)) gpio_out_q <= com.com_wdata[GPIO_W-1:0];
         if (stat_wr) {ie_tx_q, ie_rx_q} <= com.com_wdata[7:6];
         sync1_q <= gpio_in;
         sync2_q <= sync1_q;
         if (rx_push) rx_wp_q <= rx_wp_q + PW'(1);
         if (rx_pop)  rx_rp_q <= rx_rp_q + PW'(1);
         if (tx_push) tx_wp_q <= tx_wp_q + PW'(1);
         if (tx_pop)  tx_rp_q <= tx_rp_q + PW'(1);
         rx_uf_q <= rx_uf_d;
         tx_of_q <= tx_of_d;
      end
   end

   assign com.com_ack   = ack_q;
   assign com.com_rdata = rdata_q;
   assign gpio_out      = gpio_out_q;
   assign in_ready      = !rx_full;
   assign out_valid     = !tx_empty;
   assign out_data      = tx_empty ? 8'h00 : tx_head;
   assign irq           = (!rx_empty && ie_rx_q) || (tx_empty && ie_tx_q);
endmodule

// File: tb/tb_risc8_com_responder.sv
// tb/tb_risc8_com_responder.sv - bench for risc8_com_responder: directed table, corner sequences, random vs queue model
module tb_risc8_com_responder;
   localparam int         D    = 4;
   localparam logic [7:0] BASE = 8'h0C;

   logic       clk, rst;
   logic [7:0] gpio_out, gpio_in, in_data, out_data;
   logic       in_valid, in_ready, out_valid, out_ready, irq;

   risc8_com_responder_if com_if ();

   risc8_com_responder #(.BASE_ADDR(BASE), .FIFO_DEPTH(D), .GPIO_W(8)) dut (
      .clk(clk), .rst(rst), .com(com_if),
      .gpio_out(gpio_out), .gpio_in(gpio_in),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .irq(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_miss = 0;

   // Reference model: byte queues plus the register values the CPU can observe.
   bit [7:0] rxq[$];
   bit [7:0] txq[$];
   bit [7:0] m_gpio, m_g1, m_g2, m_rdata;
   bit       m_uf, m_of, m_ie_rx, m_ie_tx, m_ack;

   typedef struct {
      string    name;
      bit       req, wr;
      bit [7:0] addr, wdata;
      bit       iv;
      bit [7:0] id;
      bit       ordy;
      bit [7:0] gin;
      bit       e_ack;
      bit [7:0] e_rdata, e_gpio;
      bit       e_ir, e_ov;
      bit [7:0] e_od;
      bit       e_irq;
   } vec_t;
   vec_t tv[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_check();
      chk("com_ack",   {31'd0, com_if.com_ack}, {31'd0, m_ack});
      chk("com_rdata", {24'd0, com_if.com_rdata}, {24'd0, m_rdata});
      chk("gpio_out",  {24'd0, gpio_out}, {24'd0, m_gpio});
      chk("in_ready",  {31'd0, in_ready}, {31'd0, rxq.size() < D});
      chk("out_valid", {31'd0, out_valid}, {31'd0, txq.size() != 0});
      chk("out_data",  {24'd0, out_data}, {24'd0, (txq.size() != 0) ? txq[0] : 8'h00});
      chk("irq",       {31'd0, irq}, {31'd0, ((rxq.size() != 0) && m_ie_rx) || ((txq.size() == 0) && m_ie_tx)});
   endtask

   task automatic model_edge(input bit req, input bit wr, input bit [7:0] addr, input bit [7:0] wdata,
                             input bit iv, input bit [7:0] id, input bit ordy);
      bit [7:0] st, rd;
      bit       acc, rx_room, tx_was_full;
      if (rst) begin
         rxq.delete(); txq.delete();
         m_gpio = 0; m_g1 = 0; m_g2 = 0; m_rdata = 0;
         m_uf = 0; m_of = 0; m_ie_rx = 0; m_ie_tx = 0; m_ack = 0;
         return;
      end
      st = {m_ie_tx, m_ie_rx, m_of, m_uf, txq.size() == D, txq.size() == 0, rxq.size() == D, rxq.size() == 0};
      acc = req && !m_ack && (addr[7:2] == BASE[7:2]);
      rx_room = rxq.size() < D;
      tx_was_full = txq.size() == D;
      rd = 8'h00;
      if (txq.size() != 0 && ordy) void'(txq.pop_front());
      if (acc) begin
         case (addr[1:0])
            2'd0: if (wr) m_gpio = wdata; else rd = m_gpio;
            2'd1: if (!wr) rd = m_g2;
            2'd2: if (wr) begin
                     if (tx_was_full) m_of = 1; else txq.push_back(wdata);
                  end else begin
                     if (rxq.size() == 0) m_uf = 1; else rd = rxq.pop_front();
                  end
            2'd3: if (wr) begin
                     if (wdata[4]) m_uf = 0;
                     if (wdata[5]) m_of = 0;
                     m_ie_rx = wdata[6];
                     m_ie_tx = wdata[7];
                  end else rd = st;
         endcase
      end
      if (iv && rx_room) rxq.push_back(id);
      m_g2 = m_g1;
      m_g1 = gpio_in;
      m_ack = acc;
      m_rdata = rd;
   endtask

   // One clock: check DUT against the model, drive inputs, advance model and DUT by one edge.
   task automatic step(input bit req, input bit wr, input bit [7:0] addr, input bit [7:0] wdata,
                       input bit iv, input bit [7:0] id, input bit ordy, input bit chk_en);
      if (chk_en) model_check();
      com_if.com_req = req; com_if.com_wr = wr; com_if.com_addr = addr; com_if.com_wdata = wdata;
      in_valid = iv; in_data = id; out_ready = ordy;
      model_edge(req, wr, addr, wdata, iv, id, ordy);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input bit ordy);
      step(0, 0, 8'h00, 8'h00, 0, 8'h00, ordy, 1);
   endtask

   function automatic void add(input string name, input bit req, input bit wr, input bit [7:0] addr,
                               input bit [7:0] wdata, input bit iv, input bit [7:0] id, input bit ordy,
                               input bit [7:0] gin, input bit e_ack, input bit [7:0] e_rdata,
                               input bit [7:0] e_gpio, input bit e_ir, input bit e_ov,
                               input bit [7:0] e_od, input bit e_irq);
      vec_t v;
      v.name = name; v.req = req; v.wr = wr; v.addr = addr; v.wdata = wdata; v.iv = iv; v.id = id;
      v.ordy = ordy; v.gin = gin; v.e_ack = e_ack; v.e_rdata = e_rdata; v.e_gpio = e_gpio;
      v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_irq = e_irq;
      tv.push_back(v);
   endfunction

   initial begin
      //  name          req wr addr   wdata  iv id     rdy gin    ack rdata  gpio   ir ov od     irq
      add("idle0",      0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0);
      add("rd_stat",    1, 0, 8'h0F, 8'h00, 0, 8'h00, 0, 8'h00, 1, 8'h05, 8'h00, 1, 0, 8'h00, 0);
      add("idle",       0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0);
      add("wr_gpo",     1, 1, 8'h0C, 8'hA5, 0, 8'h00, 0, 8'h00, 1, 8'h00, 8'hA5, 1, 0, 8'h00, 0);
      add("idle",       0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'hA5, 1, 0, 8'h00, 0);
      add("rd_gpo",     1, 0, 8'h0C, 8'h00, 0, 8'h00, 0, 8'h00, 1, 8'hA5, 8'hA5, 1, 0, 8'h00, 0);
      add("gin_1",      0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h3C, 0, 8'h00, 8'hA5, 1, 0, 8'h00, 0);
      add("gin_2",      0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h3C, 0, 8'h00, 8'hA5, 1, 0, 8'h00, 0);
      add("rd_gpi",     1, 0, 8'h0D, 8'h00, 0, 8'h00, 0, 8'h3C, 1, 8'h3C, 8'hA5, 1, 0, 8'h00, 0);
      add("idle",       0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h3C, 0, 8'h00, 8'hA5, 1, 0, 8'h00, 0);
      add("rx_11",      0, 0, 8'h00, 8'h00, 1, 8'h11, 0, 8'h3C, 0, 8'h00, 8'hA5, 1, 0, 8'h00, 0);
      add("rx_22",      0, 0, 8'h00, 8'h00, 1, 8'h22, 0, 8'h3C, 0, 8'h00, 8'hA5, 1, 0, 8'h00, 0);
      add("rx_33",      0, 0, 8'h00, 8'h00, 1, 8'h33, 0, 8'h3C, 0, 8'h00, 8'hA5, 1, 0, 8'h00, 0);
      add("rx_44_full", 0, 0, 8'h00, 8'h00, 1, 8'h44, 0, 8'h3C, 0, 8'h00, 8'hA5, 0, 0, 8'h00, 0);
      add("rx_55_drop", 0, 0, 8'h00, 8'h00, 1, 8'h55, 0, 8'h3C, 0, 8'h00, 8'hA5, 0, 0, 8'h00, 0);
      add("rd_stat_rf", 1, 0, 8'h0F, 8'h00, 0, 8'h00, 0, 8'h3C, 1, 8'h06, 8'hA5, 0, 0, 8'h00, 0);
      add("idle",       0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h3C, 0, 8'h00, 8'hA5, 0, 0, 8'h00, 0);
      add("pop_11",     1, 0, 8'h0E, 8'h00, 0, 8'h00, 0, 8'h3C, 1, 8'h11, 8'hA5, 1, 0, 8'h00, 0);
      add("idle",       0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h3C, 0, 8'h00, 8'hA5, 1, 0, 8'h00, 0);
      add("pop_22",     1, 0, 8'h0E, 8'h00, 0, 8'h00, 0, 8'h3C, 1, 8'h22, 8'hA5, 1, 0, 8'h00, 0);
      add("idle",       0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h3C, 0, 8'h00, 8'hA5, 1, 0, 8'h00, 0);
      add("pop_33",     1, 0, 8'h0E, 8'h00, 0, 8'h00, 0, 8'h3C, 1, 8'h33, 8'hA5, 1, 0, 8'h00, 0);
      add("idle",       0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h3C, 0, 8'h00, 8'hA5, 1, 0, 8'h00, 0);
      add("pop_44",     1, 0, 8'h0E, 8'h00, 0, 8'h00, 0, 8'h3C, 1, 8'h44, 8'hA5, 1, 0, 8'h00, 0);
      add("idle",       0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h3C, 0, 8'h00, 8'hA5, 1, 0, 8'h00, 0);
      add("pop_under",  1, 0, 8'h0E, 8'h00, 0, 8'h00, 0, 8'h3C, 1, 8'h00, 8'hA5, 1, 0, 8'h00, 0);
      add("idle",       0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h3C, 0, 8'h00, 8'hA5, 1, 0, 8'h00, 0);
      add("rd_stat_uf", 1, 0, 8'h0F, 8'h00, 0, 8'h00, 0, 8'h3C, 1, 8'h15, 8'hA5, 1, 0, 8'h00, 0);
      add("idle",       0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h3C, 0, 8'h00, 8'hA5, 1, 0, 8'h00, 0);
      add("w1c_uf",     1, 1, 8'h0F, 8'h10, 0, 8'h00, 0, 8'h3C, 1, 8'h00, 8'hA5, 1, 0, 8'h00, 0);
      add("idle",       0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h3C, 0, 8'h00, 8'hA5, 1, 0, 8'h00, 0);
      add("rd_stat_cl", 1, 0, 8'h0F, 8'h00, 0, 8'h00, 0, 8'h3C, 1, 8'h05, 8'hA5, 1, 0, 8'h00, 0);
      add("idle",       0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h3C, 0, 8'h00, 8'hA5, 1, 0, 8'h00, 0);
      add("tx_01",      1, 1, 8'h0E, 8'h01, 0, 8'h00, 0, 8'h3C, 1, 8'h00, 8'hA5, 1, 1, 8'h01, 0);
      add("idle",       0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h3C, 0, 8'h00, 8'hA5, 1, 1, 8'h01, 0);
      add("tx_02",      1, 1, 8'h0E, 8'h02, 0, 8'h00, 0, 8'h3C, 1, 8'h00, 8'hA5, 1, 1, 8'h01, 0);
      add("idle",       0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h3C, 0, 8'h00, 8'hA5, 1, 1, 8'h01, 0);
      add("tx_03",      1, 1, 8'h0E, 8'h03, 0, 8'h00, 0, 8'h3C, 1, 8'h00, 8'hA5, 1, 1, 8'h01, 0);
      add("idle",       0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h3C, 0, 8'h00, 8'hA5, 1, 1, 8'h01, 0);
      add("tx_04",      1, 1, 8'h0E, 8'h04, 0, 8'h00, 0, 8'h3C, 1, 8'h00, 8'hA5, 1, 1, 8'h01, 0);
      add("idle",       0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h3C, 0, 8'h00, 8'hA5, 1, 1, 8'h01, 0);
      add("tx_05_drop", 1, 1, 8'h0E, 8'h05, 0, 8'h00, 0, 8'h3C, 1, 8'h00, 8'hA5, 1, 1, 8'h01, 0);
      add("idle",       0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h3C, 0, 8'h00, 8'hA5, 1, 1, 8'h01, 0);
      add("rd_stat_of", 1, 0, 8'h0F, 8'h00, 0, 8'h00, 0, 8'h3C, 1, 8'h29, 8'hA5, 1, 1, 8'h01, 0);
      add("drain_1",    0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 8'h3C, 0, 8'h00, 8'hA5, 1, 1, 8'h02, 0);
      add("drain_2",    0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 8'h3C, 0, 8'h00, 8'hA5, 1, 1, 8'h03, 0);
      add("drain_3",    0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 8'h3C, 0, 8'h00, 8'hA5, 1, 1, 8'h04, 0);
      add("drain_4",    0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 8'h3C, 0, 8'h00, 8'hA5, 1, 0, 8'h00, 0);
      add("drain_idle", 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 8'h3C, 0, 8'h00, 8'hA5, 1, 0, 8'h00, 0);
      add("miss_wr",    1, 1, 8'h20, 8'hFF, 0, 8'h00, 0, 8'h3C, 0, 8'h00, 8'hA5, 1, 0, 8'h00, 0);
      add("idle",       0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h3C, 0, 8'h00, 8'hA5, 1, 0, 8'h00, 0);
      add("b2b_first",  1, 1, 8'h0C, 8'h5A, 0, 8'h00, 0, 8'h3C, 1, 8'h00, 8'h5A, 1, 0, 8'h00, 0);
      add("b2b_second", 1, 1, 8'h0C, 8'h77, 0, 8'h00, 0, 8'h3C, 0, 8'h00, 8'h5A, 1, 0, 8'h00, 0);
      add("idle",       0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h3C, 0, 8'h00, 8'h5A, 1, 0, 8'h00, 0);
      add("ie_rx",      1, 1, 8'h0F, 8'h40, 0, 8'h00, 0, 8'h3C, 1, 8'h00, 8'h5A, 1, 0, 8'h00, 0);
      add("idle_irq0",  0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h3C, 0, 8'h00, 8'h5A, 1, 0, 8'h00, 0);
      add("push_irq1",  0, 0, 8'h00, 8'h00, 1, 8'hAB, 0, 8'h3C, 0, 8'h00, 8'h5A, 1, 0, 8'h00, 1);
      add("idle_irq1",  0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h3C, 0, 8'h00, 8'h5A, 1, 0, 8'h00, 1);

      rst = 1'b1;
      gpio_in = 8'h00;
      com_if.com_req = 0; com_if.com_wr = 0; com_if.com_addr = 0; com_if.com_wdata = 0;
      in_valid = 0; in_data = 0; out_ready = 0;
      @(negedge clk);
      step(0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0);
      step(0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0);
      rst = 1'b0;

      foreach (tv[i]) begin
         gpio_in = tv[i].gin;
         step(tv[i].req, tv[i].wr, tv[i].addr, tv[i].wdata, tv[i].iv, tv[i].id, tv[i].ordy, 1);
         chk(tv[i].name,
             {4'd0, com_if.com_ack, com_if.com_rdata, gpio_out, in_ready, out_valid, out_data, irq},
             {4'd0, tv[i].e_ack, tv[i].e_rdata, tv[i].e_gpio, tv[i].e_ir, tv[i].e_ov, tv[i].e_od, tv[i].e_irq});
      end

      // RX pop on empty with a same-cycle stream push.
      step(1, 0, 8'h0E, 8'h00, 0, 8'h00, 0, 1); chk("pop_ab", {24'd0, com_if.com_rdata}, 32'hAB);
      idle(0);
      step(1, 0, 8'h0E, 8'h00, 1, 8'hCD, 0, 1); chk("pop_empty_push", {24'd0, com_if.com_rdata}, 32'h00);
      idle(0);
      step(1, 0, 8'h0F, 8'h00, 0, 8'h00, 0, 1); chk("stat_after_uf", {24'd0, com_if.com_rdata}, 32'h74);
      idle(0);
      step(1, 0, 8'h0E, 8'h00, 0, 8'h00, 0, 1); chk("pop_cd", {24'd0, com_if.com_rdata}, 32'hCD);
      idle(0);

      // TX push into a full FIFO while the stream pops in the same cycle.
      step(1, 1, 8'h0F, 8'h30, 0, 8'h00, 0, 1);
      idle(0);
      for (int k = 0; k < D; k++) begin
         step(1, 1, 8'h0E, 8'(8'hE1 + k), 0, 8'h00, 0, 1);
         idle(0);
      end
      step(1, 1, 8'h0E, 8'hEE, 0, 8'h00, 1, 1);
      idle(0);
      step(1, 0, 8'h0F, 8'h00, 0, 8'h00, 0, 1); chk("stat_of_pop", {24'd0, com_if.com_rdata}, 32'h21);
      chk("tx_head_after", {24'd0, out_data}, 32'hE2);
      idle(1); idle(1); idle(1); idle(1);
      chk("tx_drained", {24'd0, out_valid, out_data}, 32'h0);

      for (int i = 0; i < 600; i++) begin
         bit       req;
         bit [7:0] addr;
         req  = m_ack ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
         addr = ($urandom_range(0, 9) == 0) ? 8'($urandom) : {BASE[7:2], 2'($urandom)};
         if ($urandom_range(0, 31) == 0) gpio_in = 8'($urandom);
         step(req, 1'($urandom), addr, 8'($urandom), $urandom_range(0, 2) == 0, 8'($urandom),
              $urandom_range(0, 2) == 0, 1);
      end
      idle(0);
      idle(0);

      // Reset while an ack is in flight, then a request held under reset.
      step(1, 1, 8'h0F, 8'h40, 0, 8'h00, 0, 1);
      step(1, 0, 8'h0E, 8'h00, 0, 8'h00, 0, 1);
      step(1, 0, 8'h0F, 8'h00, 0, 8'h00, 0, 1);
      rst = 1'b1;
      step(0, 0, 8'h00, 8'h00, 1, 8'h99, 0, 1);
      chk("rst_mid_ack", {24'd0, com_if.com_ack, in_ready, out_valid, irq, gpio_out[3:0]}, {24'd0, 8'b0100_0000});
      step(1, 1, 8'h0C, 8'hFF, 0, 8'h00, 0, 1);
      rst = 1'b0;
      idle(0);
      chk("rst_req_dropped", {23'd0, com_if.com_ack, gpio_out}, 32'h0);
      idle(0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
